// File: rtl/pixel_fb_writer.sv
// Framebuffer pixel writer: queues generator pixels in a FIFO, converts RGB888 to
// RGB565 and issues one req/ack write per pixel, signalling completion per shape.
module pixel_fb_writer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_px,
  input  logic [7:0]  in_py,
  input  logic [23:0] in_color,
  input  logic        in_valid,
  input  logic        in_done,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        draw_done,
  output logic        overflow,
  output logic [16:0] pix_count,
  output logic        o_dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic {W_IDLE = 1'b0, W_REQ = 1'b1} w_state_t;

  // Handshake: mem_req rises with mem_addr/mem_wdata already valid and all three
  // stay frozen until mem_ack is sampled high; the write completes on that edge.
  w_state_t    r_state;
  w_state_t    w_next_state;
  logic [31:0] r_fifo [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_ack_take;
  logic        w_draw_done;
  logic [31:0] w_head;
  logic [15:0] w_rgb565;
  logic        r_mem_req;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_overflow;
  logic        r_done_pending;
  logic        r_clr_pend;
  logic [16:0] r_pix_count;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = ((r_wr_ptr - r_rd_ptr) == DEPTH_CNT);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_rgb565 = {in_color[23:19], in_color[15:10], in_color[7:3]};

  // Entries are stored already in write format: {py, px, rgb565}.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= {in_py, in_px, w_rgb565};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= W_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_ack_take   = 1'b0;
    case (r_state)
      W_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = W_REQ;
        end
      end
      W_REQ: begin
        if (mem_ack) begin
          w_ack_take   = 1'b1;
          w_next_state = W_IDLE;
        end
      end
      default: w_next_state = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_pop) begin
      r_mem_req   <= 1'b1;
      r_mem_addr  <= w_head[31:16];
      r_mem_wdata <= w_head[15:0];
    end else if (w_ack_take) begin
      r_mem_req   <= 1'b0;
    end
  end

  assign w_draw_done = r_done_pending && w_empty && (r_state == W_IDLE) && !r_mem_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow     <= 1'b0;
      r_done_pending <= 1'b0;
      r_clr_pend     <= 1'b0;
    end else begin
      if (in_valid && w_full) r_overflow <= 1'b1;
      if (w_draw_done)        r_done_pending <= 1'b0;
      else if (in_done)       r_done_pending <= 1'b1;
      if (w_push)             r_clr_pend <= 1'b0;
      else if (w_draw_done)   r_clr_pend <= 1'b1;
    end
  end

  // The count survives the draw_done cycle and restarts at the next shape's first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_count <= '0;
    end else if (w_push && (r_clr_pend || w_draw_done)) begin
      r_pix_count <= '0;
    end else if (w_ack_take) begin
      r_pix_count <= r_pix_count + 1'b1;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = !w_empty || r_mem_req || r_done_pending;
  assign draw_done   = w_draw_done;
  assign overflow    = r_overflow;
  assign pix_count   = r_pix_count;
  assign o_dbg_state = r_state;
endmodule
